sram_line_fetcher: RTL
======================

SRAM_LINE_FETCHER -- requirements
Module: sram_line_fetcher

Interface
REQ-001 SHALL have parameter LAYERS, default 2, number of independently scrolled background layers (1..4).
REQ-002 SHALL have parameter H_RES, default 640, visible pixels per line (multiple of 4).
REQ-003 SHALL have parameter ADDR_W, default 20, SRAM word-address width.
REQ-004 SHALL have parameter MAP_WORDS, default 512, map row length in 16-bit words (power of 2; 2048 px).
REQ-005 SHALL have port Clk, input, 1, single clock for all logic.
REQ-006 SHALL have port Reset_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port line_start, input, 1, one-cycle pulse requesting fetch of line line_y.
REQ-008 SHALL have port line_y, input, 10, map row of the line to fetch.
REQ-009 SHALL have port offset, input, LAYERS*12, per-layer horizontal scroll in pixels (layer l at [12l+11:12l]).
REQ-010 SHALL have port base, input, LAYERS*ADDR_W, per-layer SRAM base word address.
REQ-011 SHALL have port sram_addr, output, ADDR_W, SRAM read address.
REQ-012 SHALL have port sram_rd, output, 1, read strobe; data returns on sram_rdata exactly one cycle later.
REQ-013 SHALL have port sram_rdata, input, 16, SRAM read data (4 palette indices, pixel 0 in [3:0]).
REQ-014 SHALL have port pix_x, input, 10, display-side pixel column.
REQ-015 SHALL have port pix_idx, output, LAYERS*4, registered per-layer palette index for pix_x.
REQ-016 SHALL have ports busy, line_done, overrun (outputs, 1 each) and clr_overrun (input, 1).

Function
REQ-017 SHALL hold two line buffers (fetch, display), each LAYERS x (H_RES/4+1) words, plus a latched offset[1:0] per layer per buffer.
REQ-018 SHALL run FSM IDLE -> FETCH -> DRAIN -> IDLE; line_start in any state enters FETCH next cycle.
REQ-019 On line_start SHALL swap buffer roles, latch line_y, offset, base into the new fetch side, and reset word counter i and layer counter l to 0.
REQ-020 In FETCH SHALL assert sram_rd each cycle with sram_addr = base[l] + line_y*MAP_WORDS + ((offset[l][11:2] + i) mod MAP_WORDS), ADDR_W-bit wrap-around addition.
REQ-021 SHALL iterate i = 0..H_RES/4 (H_RES/4+1 words) per layer, layers 0..LAYERS-1 in order, no idle cycles: LAYERS*(H_RES/4+1) reads per line.
REQ-022 SHALL write sram_rdata into fetch buffer word (l,i) one cycle after the corresponding read.
REQ-023 After the last read SHALL enter DRAIN for one cycle (final write), then pulse line_done for one cycle and return to IDLE.
REQ-024 busy SHALL be 1 in FETCH and DRAIN, 0 otherwise.
REQ-025 line_start while busy SHALL set sticky overrun, abandon the fetch (stale words remain), and restart per REQ-019; no line_done for the abandoned line.
REQ-026 clr_overrun SHALL clear overrun next cycle; simultaneous set and clear SHALL leave overrun set.
REQ-027 pix_idx[l] SHALL equal, one cycle after pix_x, pixel p = pix_x + offs[l][1:0] of display buffer layer l (word p>>2, nibble p[1:0]).
REQ-028 pix_x >= H_RES SHALL yield pix_idx = 0 for all layers.
REQ-029 Display reads and fetch writes SHALL never target the same buffer.

Reset
REQ-030 Reset_n low SHALL asynchronously force FSM IDLE, sram_rd 0, sram_addr 0, busy 0, line_done 0, overrun 0, pix_idx 0, buffer select 0; buffer contents undefined.
REQ-031 Reset asserted mid-FETCH SHALL abort without line_done; first line_start after release SHALL start a clean fetch.

Verification
REQ-032 LAYERS=2, base={0,0x10000}, offset=0, line_y=3, line_start -> reads 0x600..0x6A0 then 0x10600..0x106A0, 322 sram_rd cycles, line_done 324 cycles after line_start.
REQ-033 offset[0]=2046 (word 511, fine 2) -> layer 0 addresses 0x5FF, 0x400, 0x401...; pix_x=0 after swap returns nibble 2 of word 511's data.
REQ-034 Memory model returning data = address[15:0]; second line_start then pix_x sweep 0..639 -> pix_idx matches expected nibbles, 1-cycle latency; pix_x=700 -> 0.
REQ-035 line_start at cycle 100 of FETCH -> overrun=1, fetch restarts at i=0 next cycle, single line_done later; clr_overrun -> overrun=0.
REQ-036 Reset_n low at cycle 50 of FETCH -> sram_rd 0 immediately, busy 0, no line_done; subsequent line_start completes normally.

Source files
------------

// File: rtl/sram_line_fetcher.sv
// sram_line_fetcher
//   Prefetches one display line of up to four scrolled background layers
//   from a 16-bit SRAM into a double-buffered line store. While one buffer
//   is being filled for the next line, the other is read out pixel by pixel
//   for display. Each SRAM word carries four 4-bit palette indices.
//
// Ports
//   Clk, Reset_n      single clock, asynchronous active-low reset
//   line_start        one-cycle pulse: swap buffers and fetch row line_y
//   line_y            map row to fetch
//   offset            per-layer horizontal scroll in pixels (12 bits/layer)
//   base              per-layer SRAM base word address (ADDR_W bits/layer)
//   sram_addr/sram_rd SRAM read request; data returns one cycle later
//   sram_rdata        SRAM read data, pixel 0 in [3:0]
//   pix_x             display-side pixel column
//   pix_idx           registered per-layer palette index (4 bits/layer)
//   busy              fetch in progress (FETCH or DRAIN)
//   line_done         one-cycle pulse when a line has been fully stored
//   overrun           sticky: line_start arrived while still busy
//   clr_overrun       clears overrun (a coincident set wins)
module sram_line_fetcher #(
  parameter int LAYERS    = 2,
  parameter int H_RES     = 640,
  parameter int ADDR_W    = 20,
  parameter int MAP_WORDS = 512
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     line_start,
  input  logic [9:0]               line_y,
  input  logic [LAYERS*12-1:0]     offset,
  input  logic [LAYERS*ADDR_W-1:0] base,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic                     sram_rd,
  input  logic [15:0]              sram_rdata,
  input  logic [9:0]               pix_x,
  output logic [LAYERS*4-1:0]      pix_idx,
  output logic                     busy,
  output logic                     line_done,
  output logic                     overrun,
  input  logic                     clr_overrun
);

  // One extra word per layer so a fine scroll of 1..3 pixels still has the
  // pixels needed at the right edge of the line.
  localparam int WORDS = H_RES / 4 + 1;
  localparam int IW    = $clog2(WORDS);
  localparam int LW    = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int MW    = $clog2(MAP_WORDS);
  localparam int PW    = IW + 2;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       i_q, i_d, wr_i_q;
  logic [LW-1:0]       l_q, l_d, wr_l_q;
  logic                fbuf_q;          // buffer currently being filled
  logic                wr_en_q;
  logic                line_done_q, line_done_d;
  logic                overrun_q, overrun_d;
  logic [9:0]          y_q;
  logic [9:0]          off_q  [LAYERS]; // coarse scroll, in words
  logic [ADDR_W-1:0]   base_q [LAYERS];
  logic [1:0]          fine_q [2][LAYERS];
  logic [LAYERS*4-1:0] pix_idx_q, pix_d;
  logic [15:0]         mem_q  [2][LAYERS][WORDS];

  logic                fetching, last_read, in_range, disp_buf;
  logic [ADDR_W-1:0]   col;

  assign fetching  = (state_q == S_FETCH);
  assign last_read = (i_q == IW'(WORDS - 1)) && (l_q == LW'(LAYERS - 1));
  assign disp_buf  = ~fbuf_q;
  assign in_range  = (int'(pix_x) < H_RES);

  // ---------------------------------------------------------------- FSM
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    i_d         = i_q;
    l_d         = l_q;
    line_done_d = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (last_read) begin
          state_d = S_DRAIN;
        end else if (i_q == IW'(WORDS - 1)) begin
          i_d = '0;
          l_d = l_q + LW'(1);
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      S_DRAIN: begin
        state_d     = S_IDLE;
        line_done_d = 1'b1;
      end
      default: ;
    endcase
    // A new line request always wins, abandoning any fetch in progress.
    if (line_start) begin
      state_d     = S_FETCH;
      i_d         = '0;
      l_d         = '0;
      line_done_d = 1'b0;
    end
  end

  assign overrun_d = (overrun_q & ~clr_overrun) | (line_start & busy);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      l_q         <= '0;
      fbuf_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_i_q      <= '0;
      wr_l_q      <= '0;
      line_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      pix_idx_q   <= '0;
      y_q         <= '0;
      for (int l = 0; l < LAYERS; l++) begin
        off_q[l]     <= '0;
        base_q[l]    <= '0;
        fine_q[0][l] <= '0;
        fine_q[1][l] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // values from before this edge, independent of statement order.
      state_q     <= state_d;
      i_q         <= i_d;
      l_q         <= l_d;
      fbuf_q      <= fbuf_q ^ line_start;
      // The read issued in the cycle of a restart belongs to the abandoned
      // line; dropping it keeps it out of the buffer that becomes displayed.
      wr_en_q     <= fetching & ~line_start;
      wr_i_q      <= i_q;
      wr_l_q      <= l_q;
      line_done_q <= line_done_d;
      overrun_q   <= overrun_d;
      pix_idx_q   <= pix_d;
      if (line_start) begin
        y_q <= line_y;
        for (int l = 0; l < LAYERS; l++) begin
          off_q[l]           <= offset[12*l+2 +: 10];
          base_q[l]          <= base[ADDR_W*l +: ADDR_W];
          fine_q[~fbuf_q][l] <= offset[12*l +: 2];
        end
      end
    end
  end

  // ------------------------------------------------------------ SRAM side
  // Column wraps within the map row; the full sum wraps at ADDR_W bits.
  assign col       = (ADDR_W'(off_q[l_q]) + ADDR_W'(i_q)) & ADDR_W'(MAP_WORDS - 1);
  assign sram_rd   = fetching;
  assign sram_addr = fetching ? base_q[l_q] + (ADDR_W'(y_q) << MW) + col : '0;

  // NOTE: the line store has no reset; its contents are don't-care until
  // written, and leaving it out of reset lets it map onto plain RAM.
  always_ff @(posedge Clk) begin
    if (wr_en_q) mem_q[fbuf_q][wr_l_q][wr_i_q] <= sram_rdata;
  end

  // --------------------------------------------------------- Display side
  for (genvar g = 0; g < LAYERS; g++) begin : g_disp
    logic [PW-1:0] p;
    logic [IW-1:0] rd_i;
    logic [15:0]   w;
    assign p    = PW'(pix_x) + PW'(fine_q[disp_buf][g]);
    assign rd_i = in_range ? p[PW-1:2] : '0;
    assign w    = mem_q[disp_buf][g][rd_i];
    assign pix_d[4*g +: 4] = in_range ? w[{p[1:0], 2'b00} +: 4] : 4'h0;
  end

  assign busy      = (state_q != S_IDLE);
  assign line_done = line_done_q;
  assign overrun   = overrun_q;
  assign pix_idx   = pix_idx_q;

endmodule
